sop_pipe: RTL and testbench
===========================

// Module: sop_pipe
//
// PURPOSE
//   Parametrised, pipelined sum-of-products / product-of-sums unit.
//   Bitwise over WIDTH-bit lanes:
//     - forms NUM_TERMS two-operand terms,
//     - reduces them to one result word,
//     - drives that word and its complement.
//   Sits between a producer and a consumer via valid/ready handshakes.
//   Generalises the fixed 4-input AND-OR-INVERT gate: arbitrary width and
//   term count, selectable polarity mode, registered 2-stage pipeline with
//   backpressure.
//
// PARAMETERS
//   WIDTH      4  bits per operand lane and per result
//   NUM_TERMS  2  number of two-operand terms (>=1)
//
// PORTS
//   clk        in   1                clock, rising edge
//   rst_n      in   1                asynchronous reset, active-low
//   in_valid   in   1                input beat present
//   in_ready   out  1                unit accepts input this cycle
//   in_mode    in   1                0: OR of ANDs (SOP); 1: AND of ORs (POS)
//   in_a       in   NUM_TERMS*WIDTH  operand A; term k = in_a[k*WIDTH +: WIDTH]
//   in_b       in   NUM_TERMS*WIDTH  operand B; same packing
//   out_valid  out  1                result beat present
//   out_ready  in   1                consumer accepts result
//   out        out  WIDTH            result word
//   out_n      out  WIDTH            ~out
//   beat_cnt   out  16               count of completed output beats
//
// BEHAVIOUR
//   Reset (rst_n low, asynchronous):
//     - s1_valid=0, out_valid=0, out=0, out_n=all ones, beat_cnt=0
//     - in_ready=1 once reset is released
//   Handshakes:
//     - transfer occurs when valid&ready are high on the same rising edge
//     - in_valid, in_mode, in_a, in_b are sampled only on an input transfer
//   Stage 1 register (per term k, on input transfer):
//     - SOP: t[k] = a[k] & b[k]
//     - POS: t[k] = a[k] | b[k]
//     - registers t[] and the mode bit; sets s1_valid
//   Stage 2 register (out):
//     - SOP: out = OR over k of t[k]
//     - POS: out = AND over k of t[k]
//     - loaded when s1_valid && (!out_valid || out_ready)
//   Result outputs:
//     - out_n = ~out, combinational from the out register
//     - out_valid is set by a stage-2 load
//     - out_valid is cleared by an output transfer with no simultaneous load
//   Flow control:
//     - s1_adv = s1_valid && (!out_valid || out_ready)
//     - in_ready = !s1_valid || s1_adv (combinational; depends on out_ready)
//     - s1_valid next = in_transfer ? 1 : (s1_adv ? 0 : s1_valid)
//   Latency and throughput:
//     - accepted beat appears on out/out_valid 2 cycles later
//     - full throughput: 1 beat/cycle when out_ready held high
//   Backpressure:
//     - out_ready low holds out/out_valid stable
//     - stage 1 fills; then in_ready drops
//     - at most 2 beats held; no beat is lost or duplicated
//   Simultaneous events:
//     - output transfer + stage-2 load on one edge: new data replaces old,
//       out_valid stays 1
//     - input transfer + s1_adv on one edge: stage 1 takes the new beat
//   beat_cnt:
//     - +1 per output transfer
//     - wraps 16'hFFFF -> 0
//   Reset mid-operation:
//     - all in-flight beats discarded
//     - outputs return to reset values immediately
//   NUM_TERMS=1:
//     - out = t[0]; the reduction degenerates to a pass-through
//
// TESTING
//   1. W=4,N=2, SOP: a={4'h0,4'hF}, b={4'h0,4'h3}, out_ready=1
//      -> 2 cycles later out=4'h3, out_n=4'hC, out_valid=1.
//   2. POS: a={4'h6,4'h1}, b={4'h0,4'h2}
//      -> terms 4'h6 and 4'h3, out=4'h2, out_n=4'hD.
//   3. Stream 8 beats with out_ready=1
//      -> 8 consecutive results in order, in_ready never drops,
//         beat_cnt=8.
//   4. out_ready=0 with 3 beats offered
//      -> 2 accepted, in_ready=0 on the 3rd, out stable;
//         raise out_ready -> all 3 delivered in order.
//   5. Assert rst_n low mid-stream with 2 beats in flight
//      -> out_valid=0, out=0, out_n=4'hF, beat_cnt=0 immediately;
//         no stale beat after release.
//   6. Preload beat_cnt to 16'hFFFF via 65535 beats, send one more
//      -> beat_cnt=0.

Source files
------------

// File: rtl/sop_pipe.sv
// Two-stage pipelined sum-of-products / product-of-sums unit with valid/ready
// handshakes on both sides and a running count of delivered result beats.
module sop_pipe #(
    parameter int WIDTH     = 4,
    parameter int NUM_TERMS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_mode,
    input  logic [NUM_TERMS*WIDTH-1:0]   in_a,
    input  logic [NUM_TERMS*WIDTH-1:0]   in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out,
    output logic [WIDTH-1:0]             out_n,
    output logic [15:0]                  beat_cnt
);

    logic [NUM_TERMS-1:0][WIDTH-1:0] t_q, t_d;
    logic                            mode_q;
    logic                            s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]                out_q, red_d;
    logic                            out_valid_q, out_valid_d;
    logic [15:0]                     beat_cnt_q;

    logic in_xfer, out_xfer, s1_adv;

    assign s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        t_d = '0;
        for (int k = 0; k < NUM_TERMS; k++) begin
            if (in_mode)
                t_d[k] = in_a[k*WIDTH +: WIDTH] | in_b[k*WIDTH +: WIDTH];
            else
                t_d[k] = in_a[k*WIDTH +: WIDTH] & in_b[k*WIDTH +: WIDTH];
        end
    end

    // Reduction seeds with the identity of the selected operator.
    always_comb begin
        red_d = mode_q ? {WIDTH{1'b1}} : '0;
        for (int k = 0; k < NUM_TERMS; k++) begin
            if (mode_q)
                red_d = red_d & t_q[k];
            else
                red_d = red_d | t_q[k];
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_xfer)
            s1_valid_d = 1'b1;
        else if (s1_adv)
            s1_valid_d = 1'b0;

        out_valid_d = out_valid_q;
        if (s1_adv)
            out_valid_d = 1'b1;
        else if (out_xfer)
            out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q         <= '0;
            mode_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (in_xfer) begin
                t_q    <= t_d;
                mode_q <= in_mode;
            end
            if (s1_adv)
                out_q <= red_d;
            if (out_xfer)
                beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_n     = ~out_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_sop_pipe.sv
// Directed self-checking bench for sop_pipe (WIDTH=4, NUM_TERMS=2 plus a
// single-term instance), with hand-computed expected results.
module tb_sop_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_mode, out_ready;
    logic [7:0] in_a, in_b;
    logic       in_ready, out_valid;
    logic [3:0] out, out_n;
    logic [15:0] beat_cnt;

    logic       s_valid, s_mode, s_oready;
    logic [3:0] s_a, s_b;
    logic       s_iready, s_ovalid;
    logic [3:0] s_out, s_out_n;
    logic [15:0] s_cnt;

    int cmps = 0;
    int errs = 0;

    always #5 clk = ~clk;

    sop_pipe #(.WIDTH(4), .NUM_TERMS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_n(out_n), .beat_cnt(beat_cnt)
    );

    sop_pipe #(.WIDTH(4), .NUM_TERMS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_valid), .in_ready(s_iready), .in_mode(s_mode),
        .in_a(s_a), .in_b(s_b),
        .out_valid(s_ovalid), .out_ready(s_oready),
        .out(s_out), .out_n(s_out_n), .beat_cnt(s_cnt)
    );

    // Stream vectors: mode, a, b, expected result.
    logic       v_mode [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] v_a    [8] = '{8'h12, 8'hFF, 8'h13, 8'h80, 8'h00, 8'h00, 8'hF0, 8'hA5};
    logic [7:0] v_b    [8] = '{8'h33, 8'h84, 8'h24, 8'h08, 8'hFF, 8'h00, 8'h0F, 8'hF5};
    logic [3:0] v_exp  [8] = '{4'h3, 4'hC, 4'h3, 4'h8, 4'h0, 4'h0, 4'hF, 4'hF};

    // One clock cycle: drive at negedge, observe handshakes, advance to next negedge.
    task automatic cycle(input logic v, input logic m, input logic [7:0] a, input logic [7:0] b,
                         input logic ordy, output logic acc, output logic dlv, output logic [3:0] dval);
        in_valid = v; in_mode = m; in_a = a; in_b = b; out_ready = ordy;
        #1;
        acc  = in_valid && in_ready;
        dlv  = out_valid && out_ready;
        dval = out;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 0; in_mode = 0; in_a = '0; in_b = '0; out_ready = 1;
        s_valid = 0; s_mode = 0; s_a = '0; s_b = '0; s_oready = 1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        in_valid = 0; in_mode = 0; in_a = '0; in_b = '0; out_ready = 0;
        s_valid = 0; s_mode = 0; s_a = '0; s_b = '0; s_oready = 1;
        rst_n = 1'b0;
        #12;
        cmps++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        cmps++; if (out !== 4'h0) begin errs++; $display("FAIL reset_out got %h exp 0", out); end
        cmps++; if (out_n !== 4'hF) begin errs++; $display("FAIL reset_out_n got %h exp F", out_n); end
        cmps++; if (beat_cnt !== 16'h0) begin errs++; $display("FAIL reset_beat_cnt got %h exp 0", beat_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmps++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic single_beat(input string name, input logic m, input logic [7:0] a,
                               input logic [7:0] b, input logic [3:0] exp);
        logic acc, dlv;
        logic [3:0] dv;
        cycle(1'b1, m, a, b, 1'b1, acc, dlv, dv);
        cmps++; if (acc !== 1'b1) begin errs++; $display("FAIL %s_accept got %b exp 1", name, acc); end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc, dlv, dv);
        cmps++; if (out_valid !== 1'b1) begin errs++; $display("FAIL %s_valid got %b exp 1", name, out_valid); end
        cmps++; if (out !== exp) begin errs++; $display("FAIL %s_out got %h exp %h", name, out, exp); end
        cmps++; if (out_n !== ~exp) begin errs++; $display("FAIL %s_out_n got %h exp %h", name, out_n, ~exp); end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc, dlv, dv);
    endtask

    task automatic test_sop();
        single_beat("sop", 1'b0, 8'h0F, 8'h03, 4'h3);
    endtask

    task automatic test_pos();
        single_beat("pos", 1'b1, 8'h61, 8'h02, 4'h2);
    endtask

    task automatic test_back_to_back();
        logic acc, dlv;
        logic [3:0] dv;
        int tx = 0, rx = 0, drops = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            if (tx < 8) cycle(1'b1, v_mode[tx], v_a[tx], v_b[tx], 1'b1, acc, dlv, dv);
            else        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc, dlv, dv);
            if (tx < 8 && !acc) drops++;
            if (acc) tx++;
            if (dlv) begin
                cmps++;
                if (rx >= 8 || dv !== v_exp[rx]) begin
                    errs++; $display("FAIL stream_data idx %0d got %h exp %h", rx, dv, (rx < 8) ? v_exp[rx] : 4'hx);
                end
                rx++;
            end
        end
        cmps++; if (drops != 0) begin errs++; $display("FAIL stream_in_ready dropped %0d times exp 0", drops); end
        cmps++; if (rx != 8) begin errs++; $display("FAIL stream_count got %0d exp 8", rx); end
        cmps++; if (beat_cnt !== 16'd8) begin errs++; $display("FAIL stream_beat_cnt got %0d exp 8", beat_cnt); end
    endtask

    task automatic test_backpressure();
        logic acc, dlv;
        logic [3:0] dv;
        int tx, rx;
        do_reset();
        cycle(1'b1, v_mode[0], v_a[0], v_b[0], 1'b0, acc, dlv, dv);
        cmps++; if (acc !== 1'b1) begin errs++; $display("FAIL bp_accept0 got %b exp 1", acc); end
        cycle(1'b1, v_mode[1], v_a[1], v_b[1], 1'b0, acc, dlv, dv);
        cmps++; if (acc !== 1'b1) begin errs++; $display("FAIL bp_accept1 got %b exp 1", acc); end
        for (int c = 0; c < 2; c++) begin
            cycle(1'b1, v_mode[2], v_a[2], v_b[2], 1'b0, acc, dlv, dv);
            cmps++; if (acc !== 1'b0) begin errs++; $display("FAIL bp_stall_accept cyc %0d got %b exp 0", c, acc); end
            cmps++; if (out_valid !== 1'b1 || out !== v_exp[0]) begin
                errs++; $display("FAIL bp_hold cyc %0d got valid %b out %h exp 1 %h", c, out_valid, out, v_exp[0]);
            end
        end
        tx = 2; rx = 0;
        for (int c = 0; c < 8; c++) begin
            if (tx < 3) cycle(1'b1, v_mode[tx], v_a[tx], v_b[tx], 1'b1, acc, dlv, dv);
            else        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc, dlv, dv);
            if (acc) tx++;
            if (dlv) begin
                cmps++;
                if (rx >= 3 || dv !== v_exp[rx]) begin
                    errs++; $display("FAIL bp_data idx %0d got %h exp %h", rx, dv, (rx < 3) ? v_exp[rx] : 4'hx);
                end
                rx++;
            end
        end
        cmps++; if (rx != 3) begin errs++; $display("FAIL bp_count got %0d exp 3", rx); end
    endtask

    task automatic test_reset_mid();
        logic acc, dlv;
        logic [3:0] dv;
        int stale = 0;
        do_reset();
        single_beat("pre_rst", 1'b0, 8'hFF, 8'hFF, 4'hF);
        cycle(1'b1, v_mode[1], v_a[1], v_b[1], 1'b0, acc, dlv, dv);
        cycle(1'b1, v_mode[3], v_a[3], v_b[3], 1'b0, acc, dlv, dv);
        cmps++; if (beat_cnt !== 16'd1) begin errs++; $display("FAIL rst_mid_pre_cnt got %0d exp 1", beat_cnt); end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        cmps++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_valid got %b exp 0", out_valid); end
        cmps++; if (out !== 4'h0 || out_n !== 4'hF) begin errs++; $display("FAIL rst_mid_out got %h/%h exp 0/F", out, out_n); end
        cmps++; if (beat_cnt !== 16'd0) begin errs++; $display("FAIL rst_mid_cnt got %0d exp 0", beat_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc, dlv, dv);
            if (dlv) stale++;
        end
        cmps++; if (stale != 0) begin errs++; $display("FAIL rst_mid_stale got %0d beats exp 0", stale); end
    endtask

    task automatic test_wrap();
        logic acc, dlv;
        logic [3:0] dv;
        int tx = 0;
        do_reset();
        for (int c = 0; c < 65600 && tx < 65535; c++) begin
            cycle(1'b1, 1'b0, 8'h11, 8'h11, 1'b1, acc, dlv, dv);
            if (acc) tx++;
        end
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc, dlv, dv);
        cmps++; if (beat_cnt !== 16'hFFFF) begin errs++; $display("FAIL wrap_pre got %h exp FFFF", beat_cnt); end
        cycle(1'b1, 1'b0, 8'h11, 8'h11, 1'b1, acc, dlv, dv);
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc, dlv, dv);
        cmps++; if (beat_cnt !== 16'h0000) begin errs++; $display("FAIL wrap_post got %h exp 0000", beat_cnt); end
    endtask

    task automatic test_single_term();
        logic [3:0] exp_v [2] = '{4'h1, 4'hB};
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_mode = (i == 1); s_a = 4'h9; s_b = 4'h3; s_oready = 1'b1;
            @(negedge clk);
            s_valid = 1'b0;
            @(negedge clk);
            cmps++; if (s_ovalid !== 1'b1 || s_out !== exp_v[i] || s_out_n !== ~exp_v[i]) begin
                errs++; $display("FAIL n1_mode%0d got valid %b out %h out_n %h exp 1 %h %h",
                                 i, s_ovalid, s_out, s_out_n, exp_v[i], ~exp_v[i]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sop();
        test_pos();
        test_single_term();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
